run_controller: RTL

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// Run controller: sequences processor reset, free-running execution,
// single-stepping and halting on a halt opcode, a breakpoint or a cycle budget.
module run_controller #(
    parameter int             INSTR_W    = 8,
    parameter int             ADDR_W     = 8,
    parameter int             OPC_W      = 4,
    parameter logic [OPC_W-1:0] HALT_OPC = 4'b1111,
    parameter int             CNT_W      = 16,
    parameter int             RST_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic               abort,
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               bp_en,
    input  logic [ADDR_W-1:0]  bp_addr,
    input  logic [CNT_W-1:0]   cycle_limit,
    output logic               cpu_en,
    output logic               cpu_reset,
    output logic [2:0]         run_state,
    output logic [1:0]         halt_cause,
    output logic [CNT_W-1:0]   cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_RST    = 3'b001,
        ST_RUN    = 3'b010,
        ST_STEP   = 3'b011,
        ST_HALTED = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_OPC   = 2'b01,
        CAUSE_BP    = 2'b10,
        CAUSE_LIMIT = 2'b11
    } cause_t;

    // The reset-pulse counter only needs to reach RST_CYCLES-1.
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    cause_t           halt_cause_q, halt_cause_d;
    logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             bp_mask_q, bp_mask_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             cpu_en_d;
    logic             clear_count;

    logic hc_opc, hc_bp, hc_lim, hc;

    // Operand bits below the opcode field are not interpreted here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr;

    // Halt condition terms, evaluated against the instruction currently presented.
    always_comb begin
        hc_opc = (instr[INSTR_W-1 -: OPC_W] == HALT_OPC);
        hc_bp  = bp_en && (pc == bp_addr) && !bp_mask_q;
        hc_lim = (cycle_limit != '0) && (cycle_count_q == cycle_limit);
        hc     = hc_opc || hc_bp || hc_lim;
    end

    // Next-state, clock-enable and bookkeeping logic; abort beats start beats step.
    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        rst_cnt_d    = rst_cnt_q;
        bp_mask_d    = bp_mask_q;
        cpu_en_d     = 1'b0;
        clear_count  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    state_d      = ST_RST;
                    rst_cnt_d    = '0;
                    halt_cause_d = CAUSE_NONE;
                    clear_count  = 1'b1;
                end
            end
            ST_RST: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // The resume mask only protects the first cycle after a resume.
                bp_mask_d = 1'b0;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hc) begin
                    state_d = ST_HALTED;
                    if (hc_opc)
                        halt_cause_d = CAUSE_OPC;
                    else if (hc_bp)
                        halt_cause_d = CAUSE_BP;
                    else
                        halt_cause_d = CAUSE_LIMIT;
                end else begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d      = ST_RUN;
                    halt_cause_d = CAUSE_NONE;
                    bp_mask_d    = 1'b1;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // A single step ignores breakpoint and budget, but never runs a halt opcode.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HALTED;
                    if (hc_opc)
                        halt_cause_d = CAUSE_OPC;
                    else
                        cpu_en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE)
            bp_mask_d = 1'b0;

        // Count executed cycles, saturating rather than wrapping.
        if (clear_count)
            cycle_count_d = '0;
        else if (cpu_en_d && (cycle_count_q != CNT_MAX))
            cycle_count_d = cycle_count_q + 1'b1;
        else
            cycle_count_d = cycle_count_q;

        // Processor is held in reset whenever the controller is idle or pulsing reset.
        cpu_reset_d = (state_d == ST_IDLE) || (state_d == ST_RST);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            halt_cause_q  <= CAUSE_NONE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            bp_mask_q     <= 1'b0;
            cpu_reset_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            halt_cause_q  <= halt_cause_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            bp_mask_q     <= bp_mask_d;
            cpu_reset_q   <= cpu_reset_d;
        end
    end

    assign cpu_en      = cpu_en_d;
    assign cpu_reset   = cpu_reset_q;
    assign run_state   = state_q;
    assign halt_cause  = halt_cause_q;
    assign cycle_count = cycle_count_q;

endmodule
